// File: rtl/tile_fetch_if.sv
// Bundles the video, tile-write handshake and tile-query signals of tile_fetch.
// The master drives coordinates and requests; the slave (tile_fetch) drives the sprite_map outputs.
interface tile_fetch_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       hsync;
  logic       vsync;

  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_col;
  logic [4:0] wr_row;
  logic [3:0] wr_code;

  logic [4:0] rd_col;
  logic [4:0] rd_row;
  logic [3:0] rd_code;

  logic [2:0] sx;
  logic [2:0] sy;
  logic [3:0] sprite_code;
  logic       de_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       busy;

  modport master (
    output x, y, de, hsync, vsync,
    output wr_valid, wr_col, wr_row, wr_code,
    output rd_col, rd_row,
    input  wr_ready, rd_code, sx, sy, sprite_code, de_o, hsync_o, vsync_o, busy
  );

  modport slave (
    input  x, y, de, hsync, vsync,
    input  wr_valid, wr_col, wr_row, wr_code,
    input  rd_col, rd_row,
    output wr_ready, rd_code, sx, sy, sprite_code, de_o, hsync_o, vsync_o, busy
  );
endinterface

// File: rtl/tile_fetch.sv
// Screen coordinate -> maze tile lookup; video path 2 cycles, query 1 cycle.
// Writes are refused (wr_ready=0) during the post-reset clear sweep, always accepted afterwards.
module tile_fetch #(
  parameter int         X0        = 208,
  parameter int         Y0        = 116,
  parameter int         COLS      = 28,
  parameter int         ROWS      = 31,
  parameter logic [3:0] INIT_CODE = 4'b1001
) (
  input  logic       clk,
  input  logic       rst,
  tile_fetch_if.slave bus
);
  localparam int         DEPTH = COLS * ROWS;
  localparam logic [9:0] LAST  = 10'(DEPTH - 1);
  localparam logic [9:0] X_LO  = 10'(X0);
  localparam logic [9:0] X_HI  = 10'(X0 + 8 * COLS);
  localparam logic [9:0] Y_LO  = 10'(Y0);
  localparam logic [9:0] Y_HI  = 10'(Y0 + 8 * ROWS);
  localparam logic [3:0] BLANK = 4'b1111;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t     state;
  logic [9:0] clr_cnt;
  logic       busy_q;
  logic       wr_ready_q;

  logic [3:0] mem [DEPTH];

  // Write port shared between the clear sweep and game-logic writes
  logic       wr_in_range;
  logic [9:0] wr_addr;
  logic       we;
  logic [9:0] waddr;
  logic [3:0] wdata;

  assign wr_in_range = (bus.wr_col < 5'(COLS)) && (bus.wr_row < 5'(ROWS));
  assign wr_addr     = 10'(bus.wr_row) * 10'(COLS) + 10'(bus.wr_col);

  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = bus.wr_code;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = INIT_CODE;
    end else if (bus.wr_valid && wr_in_range) begin
      we = 1'b1;
    end
  end

  // Non-blocking write: same-edge reads on both ports see the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      busy_q     <= 1'b1;
      wr_ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state      <= RUN;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Video stage 1: tile address and in-tile offsets
  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_map;
  logic [9:0] v_addr;

  assign dx     = bus.x - X_LO;
  assign dy     = bus.y - Y_LO;
  assign in_map = (bus.x >= X_LO) && (bus.x < X_HI) && (bus.y >= Y_LO) && (bus.y < Y_HI);
  assign v_addr = 10'(dy[9:3]) * 10'(COLS) + 10'(dx[9:3]);

  logic [9:0] s1_addr;
  logic [2:0] s1_ox;
  logic [2:0] s1_oy;
  logic       s1_in_map;
  logic       s1_de;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_addr   <= '0;
      s1_ox     <= '0;
      s1_oy     <= '0;
      s1_in_map <= 1'b0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_run    <= 1'b0;
    end else begin
      s1_addr   <= in_map ? v_addr : 10'd0;
      s1_ox     <= dx[2:0];
      s1_oy     <= dy[2:0];
      s1_in_map <= in_map;
      s1_de     <= bus.de;
      s1_hs     <= bus.hsync;
      s1_vs     <= bus.vsync;
      s1_run    <= (state == RUN);
    end
  end

  // Video stage 2 and query port
  logic       rd_in_range;
  logic [9:0] rd_addr;
  logic [3:0] sprite_code_q;
  logic [3:0] rd_code_q;
  logic [2:0] sx_q;
  logic [2:0] sy_q;
  logic       de_q;
  logic       hs_q;
  logic       vs_q;

  assign rd_in_range = (bus.rd_col < 5'(COLS)) && (bus.rd_row < 5'(ROWS));
  assign rd_addr     = rd_in_range ? 10'(bus.rd_row) * 10'(COLS) + 10'(bus.rd_col) : 10'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sprite_code_q <= BLANK;
      rd_code_q     <= BLANK;
      sx_q          <= '0;
      sy_q          <= '0;
      de_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
    end else begin
      sprite_code_q <= (s1_in_map && s1_de && s1_run) ? mem[s1_addr] : BLANK;
      rd_code_q     <= (state == RUN && rd_in_range) ? mem[rd_addr] : BLANK;
      sx_q          <= s1_in_map ? s1_ox : 3'd0;
      sy_q          <= s1_in_map ? s1_oy : 3'd0;
      de_q          <= s1_de;
      hs_q          <= s1_hs;
      vs_q          <= s1_vs;
    end
  end

  assign bus.sprite_code = sprite_code_q;
  assign bus.rd_code     = rd_code_q;
  assign bus.sx          = sx_q;
  assign bus.sy          = sy_q;
  assign bus.de_o        = de_q;
  assign bus.hsync_o     = hs_q;
  assign bus.vsync_o     = vs_q;
  assign bus.busy        = busy_q;
  assign bus.wr_ready    = wr_ready_q;
endmodule

// File: tb/tb_tile_fetch.sv
// Randomised and directed bench for tile_fetch against a tile-map model built from screen geometry.
module tb_tile_fetch;
  logic clk;
  logic rst;
  tile_fetch_if bus ();

  tile_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Model: expected outputs derived from the maze geometry and a plain tile array
  logic [3:0] e_sc, e_rd;
  logic [2:0] e_sx, e_sy;
  logic       e_de, e_hs, e_vs, e_busy, e_rdy;
  int unsigned k_edges;
  logic [3:0] mmem [868];
  logic [9:0] px, py;
  logic       pde, phs, pvs, prun;
  int         xo, yo;
  bit         run_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k_edges = 0;
      px = '0; py = '0; pde = 1'b0; phs = 1'b0; pvs = 1'b0; prun = 1'b0;
      e_sc = 4'hF; e_rd = 4'hF; e_sx = '0; e_sy = '0;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_busy = 1'b1; e_rdy = 1'b0;
      for (int i = 0; i < 868; i++) mmem[i] = 4'b1001;
    end else begin
      run_now = (k_edges >= 868);
      if (run_now && bus.rd_col < 5'd28 && bus.rd_row < 5'd31)
        e_rd = mmem[int'(bus.rd_row) * 28 + int'(bus.rd_col)];
      else
        e_rd = 4'hF;
      xo = int'(px) - 208;
      yo = int'(py) - 116;
      if (xo >= 0 && xo < 224 && yo >= 0 && yo < 248) begin
        e_sx = 3'(xo % 8);
        e_sy = 3'(yo % 8);
        e_sc = (pde && prun) ? mmem[(yo / 8) * 28 + xo / 8] : 4'hF;
      end else begin
        e_sx = '0; e_sy = '0; e_sc = 4'hF;
      end
      e_de = pde; e_hs = phs; e_vs = pvs;
      px = bus.x; py = bus.y; pde = bus.de; phs = bus.hsync; pvs = bus.vsync; prun = run_now;
      if (run_now && bus.wr_valid && bus.wr_col < 5'd28 && bus.wr_row < 5'd31)
        mmem[int'(bus.wr_row) * 28 + int'(bus.wr_col)] = bus.wr_code;
      k_edges++;
      e_busy = (k_edges < 868);
      e_rdy  = !e_busy;
    end
  end

  logic [18:0] act_v, exp_v;
  always @(negedge clk) begin
    act_v = {bus.sprite_code, bus.rd_code, bus.sx, bus.sy, bus.de_o, bus.hsync_o, bus.vsync_o,
             bus.busy, bus.wr_ready};
    exp_v = {e_sc, e_rd, e_sx, e_sy, e_de, e_hs, e_vs, e_busy, e_rdy};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t got sc=%h rd=%h sx=%0d sy=%0d de/hs/vs=%b%b%b busy=%b rdy=%b want sc=%h rd=%h sx=%0d sy=%0d de/hs/vs=%b%b%b busy=%b rdy=%b",
               $time, bus.sprite_code, bus.rd_code, bus.sx, bus.sy, bus.de_o, bus.hsync_o,
               bus.vsync_o, bus.busy, bus.wr_ready, e_sc, e_rd, e_sx, e_sy, e_de, e_hs, e_vs,
               e_busy, e_rdy);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'({bus.sprite_code, bus.rd_code, bus.sx, bus.sy, bus.de_o, bus.hsync_o,
                     bus.vsync_o, bus.busy, bus.wr_ready}),
          32'({4'hF, 4'hF, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  // Called just after a negedge; checks two cycles later
  task automatic pix(input int xi, input int yi, input logic de_i, input string name,
                     input logic [3:0] sc, input logic [2:0] sxe, input logic [2:0] sye);
    bus.x = 10'(xi); bus.y = 10'(yi); bus.de = de_i;
    repeat (2) @(negedge clk);
    check({name, "_code"}, 32'(bus.sprite_code), 32'(sc));
    check({name, "_sx"}, 32'(bus.sx), 32'(sxe));
    check({name, "_sy"}, 32'(bus.sy), 32'(sye));
    check({name, "_de"}, 32'(bus.de_o), 32'(de_i));
  endtask

  task automatic query(input int c, input int r, input logic [3:0] exp, input string name);
    bus.rd_col = 5'(c); bus.rd_row = 5'(r);
    @(negedge clk);
    check(name, 32'(bus.rd_code), 32'(exp));
  endtask

  task automatic write_tile(input int c, input int r, input logic [3:0] code, input string name);
    bus.wr_valid = 1'b1; bus.wr_col = 5'(c); bus.wr_row = 5'(r); bus.wr_code = code;
    check({name, "_ready"}, 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bus.busy) break;
    end
    check(name, 32'(n), 32'd868);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.x        = 10'($urandom_range(190, 450));
      bus.y        = 10'($urandom_range(100, 380));
      bus.de       = ($urandom_range(0, 3) != 0);
      bus.hsync    = 1'($urandom);
      bus.vsync    = 1'($urandom);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_col   = 5'($urandom_range(0, 29));
      bus.wr_row   = 5'($urandom_range(0, 32));
      bus.wr_code  = 4'($urandom);
      bus.rd_col   = 5'($urandom_range(0, 29));
      bus.rd_row   = 5'($urandom_range(0, 32));
      @(negedge clk);
    end
    bus.wr_valid = 1'b0; bus.de = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    bus.x = '0; bus.y = '0; bus.de = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_code = '0;
    bus.rd_col = '0; bus.rd_row = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_values");
    #2 rst = 1'b0;
    count_clear("clear_len");

    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++)
        query(c, r, 4'b1001, "tile_init");

    pix(208, 116, 1'b1, "pix_origin", 4'b1001, 3'd0, 3'd0);
    pix(215, 123, 1'b1, "pix_off77", 4'b1001, 3'd7, 3'd7);
    pix(207, 116, 1'b1, "pix_left", 4'hF, 3'd0, 3'd0);
    pix(432, 116, 1'b1, "pix_right", 4'hF, 3'd0, 3'd0);
    pix(208, 115, 1'b1, "pix_top", 4'hF, 3'd0, 3'd0);
    pix(208, 364, 1'b1, "pix_bottom", 4'hF, 3'd0, 3'd0);
    pix(300, 200, 1'b0, "pix_de0", 4'hF, 3'd4, 3'd4);

    write_tile(27, 30, 4'b1010, "wr_27_30");
    query(27, 30, 4'b1010, "q_27_30");
    pix(431, 363, 1'b1, "pix_27_30", 4'b1010, 3'd7, 3'd7);
    // x=423 is the last pixel column of tile 26, untouched by the write
    pix(423, 363, 1'b1, "pix_26_30", 4'b1001, 3'd7, 3'd7);
    bus.de = 1'b0;

    write_tile(28, 0, 4'b0000, "wr_oor");
    query(0, 1, 4'b1001, "q_tile01_kept");
    query(28, 0, 4'hF, "q_col28");
    query(3, 31, 4'hF, "q_row31");

    rand_cycles(3000);

    // Reset mid-RUN with live outputs
    bus.de = 1'b1; bus.hsync = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_mid_run");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check(
        "de_pass_in_clear", 32'(bus.de_o), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_mid_clear");
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_col = 5'd3; bus.wr_row = 5'd4; bus.wr_code = 4'b0101;
    #2 rst = 1'b0;
    count_clear("clear_len_again");
    check("ready_first_run", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    query(3, 4, 4'b0101, "q_held_write");
    query(4, 3, 4'b1001, "q_neighbour");

    rand_cycles(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
